if_mem_responder: RTL and testbench

Memory-side responder for the instruction-fetch read port: serves the fetch stage's word reads from an internal word array after a fixed number of wait states. It sits between the fetch stage and the instruction store, completing the address/read/resp/rdata handshake the fetch stage drives. A backdoor load port fills the array from the bench or the boot loader.

---
 rtl/if_mem_responder.sv | 108 ++++++++++
 tb/tb_if_mem_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/if_mem_responder.sv
// if_mem_responder: fetch-port word-read responder with fixed wait states and a backdoor load port.
// Optional last-word hit register enabled by defining IF_MEM_RESPONDER_HIT_EN.
module if_mem_responder #(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_BITS   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] mem_addr,
   input  logic        mem_read,
   input  logic [1:0]  mem_byte_enable,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   input  logic        load_en,
   input  logic [15:0] load_addr,
   input  logic [15:0] load_data
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
   logic [15:0] mem_q [2**ADDR_BITS];
   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] req_idx_q, req_idx_d;
   logic [15:0] rdata_q, rdata_d;
   logic [ADDR_BITS-1:0] idx, load_idx;
   logic [15:0] fill_data, hit_fill;
   logic hit, unused_bits;
   assign idx = mem_addr[ADDR_BITS:1];
   assign load_idx = load_addr[ADDR_BITS:1];
   assign unused_bits = ^{mem_byte_enable, mem_addr[0], load_addr[0],
                          mem_addr[15:ADDR_BITS+1], load_addr[15:ADDR_BITS+1]};
   // A load to the word being captured wins over the stale array contents
   assign fill_data = (load_en && load_idx == req_idx_d) ? load_data : mem_q[req_idx_d];
   assign mem_resp = (state_q == RESP) && mem_read && (idx == req_idx_q);
   assign mem_rdata = rdata_q;
`ifdef IF_MEM_RESPONDER_HIT_EN
   logic hit_valid_q, hit_valid_d;
   logic [ADDR_BITS-1:0] hit_idx_q, hit_idx_d;
   logic [15:0] hit_data_q, hit_data_d;
   assign hit = hit_valid_q && (idx == hit_idx_q);
   assign hit_fill = (load_en && load_idx == hit_idx_q) ? load_data : hit_data_q;
   always_comb begin
      hit_valid_d = hit_valid_q | mem_resp;
      hit_idx_d = mem_resp ? req_idx_q : hit_idx_q;
      hit_data_d = hit_data_q;
      if (mem_resp)
         hit_data_d = (load_en && load_idx == req_idx_q) ? load_data : rdata_q;
      else if (load_en && load_idx == hit_idx_q)
         hit_data_d = load_data;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_valid_q <= 1'b0;
         hit_idx_q <= '0;
         hit_data_q <= '0;
      end else begin
         hit_valid_q <= hit_valid_d;
         hit_idx_q <= hit_idx_d;
         hit_data_q <= hit_data_d;
      end
   end
`else
   assign hit = 1'b0;
   assign hit_fill = '0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      req_idx_d = req_idx_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && mem_read) begin
         req_idx_d = idx;
         cnt_d = CNT_INIT;
         state_d = (hit || WAIT_STATES == 0) ? RESP : WAIT;
      end else if (state_q == WAIT) begin
         if (!mem_read)
            state_d = IDLE;
         else if (idx != req_idx_q) begin
            req_idx_d = idx;
            cnt_d = CNT_INIT;
            state_d = (WAIT_STATES == 0) ? RESP : WAIT;
         end else if (cnt_q == 4'd0)
            state_d = RESP;
         else
            cnt_d = cnt_q - 4'd1;
      end else if (state_q == RESP)
         state_d = IDLE;
      if (state_d == RESP && state_q != RESP)
         rdata_d = (state_q == IDLE && hit) ? hit_fill : fill_data;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         req_idx_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         req_idx_q <= req_idx_d;
         rdata_q <= rdata_d;
      end
   end
   always_ff @(posedge clk) begin
      if (load_en)
         mem_q[load_idx] <= load_data;
   end
endmodule

// File: tb/tb_if_mem_responder.sv
// tb_if_mem_responder: directed vector table plus hand sequences for reset, redirect and repeat reads.
module tb_if_mem_responder;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [15:0] mem_addr = '0, load_addr = '0, load_data = '0, mem_rdata;
   logic mem_read = 1'b0, load_en = 1'b0, mem_resp;
   logic [1:0] mem_byte_enable = 2'b11;
   int n_cmp = 0, n_err = 0;
   typedef struct {
      logic [15:0] addr;
      logic rd;
      logic le;
      logic [15:0] la;
      logic [15:0] ld;
      logic resp;
      logic chk_d;
      logic [15:0] data;
   } vec_t;
   vec_t v[18];
   if_mem_responder #(.WAIT_STATES(2), .ADDR_BITS(8)) dut (
      .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic cyc(input string name, input logic [15:0] a, input logic r, input logic le,
                      input logic [15:0] la, input logic [15:0] ld, input logic er,
                      input logic cd, input logic [15:0] ed);
      @(posedge clk);
      #1;
      mem_addr = a;
      mem_read = r;
      load_en = le;
      load_addr = la;
      load_data = ld;
      @(negedge clk);
      chk({name, " resp"}, {15'd0, mem_resp}, {15'd0, er});
      if (cd) chk({name, " rdata"}, mem_rdata, ed);
   endtask
   initial begin
      int second;
      v[0]  = '{16'h0000, 1'b0, 1'b1, 16'h0010, 16'hA5C3, 1'b0, 1'b0, 16'h0000};
      v[1]  = '{16'h0000, 1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0, 1'b0, 16'h0000};
      v[2]  = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[3]  = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[4]  = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[5]  = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hA5C3};
      v[6]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hA5C3};
      v[7]  = '{16'h0203, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[8]  = '{16'h0203, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[9]  = '{16'h0203, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[10] = '{16'h0203, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234};
      v[11] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234};
      v[12] = '{16'h0000, 1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0, 1'b0, 16'h0000};
      v[13] = '{16'h0030, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[14] = '{16'h0030, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      v[15] = '{16'h0030, 1'b1, 1'b1, 16'h0031, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
      v[16] = '{16'h0030, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
      v[17] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset resp", {15'd0, mem_resp}, 16'd0);
      chk("reset rdata", mem_rdata, 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 18; i++)
         cyc($sformatf("vec%0d", i), v[i].addr, v[i].rd, v[i].le, v[i].la, v[i].ld,
             v[i].resp, v[i].chk_d, v[i].data);
      // Reset lands while the request sits in WAIT; it must vanish
      cyc("rst_acc", 16'h0010, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
      cyc("rst_wait", 16'h0010, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      chk("midrst resp", {15'd0, mem_resp}, 16'd0);
      chk("midrst rdata", mem_rdata, 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 6; i++)
         cyc($sformatf("postrst%0d", i), 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0000);
      cyc("ld20", 16'h0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 1'b0, 16'h0);
      cyc("ld40", 16'h0, 1'b0, 1'b1, 16'h0040, 16'h2222, 1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 6; k++)
         cyc($sformatf("redir%0d", k), (k < 2) ? 16'h0020 : 16'h0040, 1'b1, 1'b0, 16'h0, 16'h0,
             k == 5, k == 5, 16'h2222);
      cyc("redir_idle", 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h2222);
`ifdef IF_MEM_RESPONDER_HIT_EN
      second = 5;
`else
      second = 7;
`endif
      for (int k = 0; k <= second; k++)
         cyc($sformatf("rep%0d", k), 16'h0010, 1'b1, 1'b0, 16'h0, 16'h0,
             (k == 3) || (k == second), (k == 3) || (k == second), 16'hA5C3);
      cyc("rep_end", 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hA5C3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
